// File: rtl/correlator_tdm_if.sv
// rtl/correlator_tdm_if.sv - control, sample and visibility bundle for correlator_tdm
//
// Groups the correlator's handshake and data signals.
//   master : capture/readout side; drives en, sw, re, im and observes results
//   slave  : correlator side; consumes samples, produces vld/vis/vis_idx and swap status
interface correlator_tdm_if #(
    parameter int NANT  = 24,
    parameter int ACCUM = 24,
    parameter int TBITS = 4
);
    logic                 en;
    logic                 sw;
    logic [NANT-1:0]      re;
    logic [NANT-1:0]      im;
    logic                 vld;
    logic [2*ACCUM-1:0]   vis;
    logic [TBITS-1:0]     vis_idx;
    logic                 swack;
    logic                 pending;
    logic                 overflow_cos;
    logic                 overflow_sin;

    modport master (
        output en, sw, re, im,
        input  vld, vis, vis_idx, swack, pending, overflow_cos, overflow_sin
    );

    modport slave (
        input  en, sw, re, im,
        output vld, vis, vis_idx, swack, pending, overflow_cos, overflow_sin
    );
endinterface

// File: rtl/correlator_tdm.sv
// rtl/correlator_tdm.sv - time-multiplexed 1-bit cos/sin correlator with frame-aligned bank swap
//
// One antenna pair per enabled cycle, taken from the PAIRS table by slot index.
// Accumulators live in a 2^TBITS-deep distributed RAM holding {sin, cos}.
// Ports:
//   clk_x        correlator clock
//   rst_n        asynchronous active-low reset
//   bus.en       process the current slot this cycle
//   bus.sw       bank-swap request pulse
//   bus.re/im    per-antenna sign bits, stable for a frame
//   bus.vld      vis/vis_idx carry a finished-block value
//   bus.vis      {sin, cos} of the finished block, bus.vis_idx its slot
//   bus.swack    one-cycle pulse when a requested swap starts
//   bus.pending  swap requested but not yet started
//   bus.overflow_cos/sin  overflow seen in the block just closed
module correlator_tdm #(
    parameter int NANT     = 24,
    parameter int ABITS    = 5,
    parameter int TRATE    = 12,
    parameter int TBITS    = 4,
    parameter int ACCUM    = 24,
    parameter int SATURATE = 1,
    parameter logic [TRATE*2*ABITS-1:0] PAIRS = {
        5'd23, 5'd11, 5'd22, 5'd10, 5'd21, 5'd9,  5'd20, 5'd8,
        5'd19, 5'd7,  5'd18, 5'd6,  5'd17, 5'd5,  5'd16, 5'd4,
        5'd15, 5'd3,  5'd14, 5'd2,  5'd13, 5'd1,  5'd12, 5'd0
    },
    parameter int DELAY    = 3
) (
    input  logic              clk_x,
    input  logic              rst_n,
    correlator_tdm_if.slave   bus
);
    if (TRATE < 3 || TRATE > (1 << TBITS) || (1 << ABITS) < NANT || DELAY < 0) begin : g_bad_params
        $error("correlator_tdm: illegal parameter combination");
    end

    localparam logic [TBITS-1:0] LAST = TBITS'(TRATE - 1);
    localparam logic [ACCUM-1:0] ONES = '1;

    logic [2*ACCUM-1:0] mem [2**TBITS];

    logic [TBITS-1:0]   slot;
    logic               forced_clr;
    logic               in_clr;
    logic               in_silent;
    logic               pending_q;
    logic               swack_q;
    logic               sticky_cos;
    logic               sticky_sin;
    logic               ovf_cos_q;
    logic               ovf_sin_q;

    // stage A: one slot's operands, captured on the edge after its enabled cycle
    logic               a_vld;
    logic [TBITS-1:0]   a_slot;
    logic               a_cinc;
    logic               a_sinc;
    logic               a_clr;
    logic               a_emit;
    logic [2*ACCUM-1:0] a_old;

    logic               vld_q;
    logic [2*ACCUM-1:0] vis_q;
    logic [TBITS-1:0]   vis_idx_q;

    logic [2*ABITS-1:0] pair;
    logic [ABITS-1:0]   idx_a;
    logic [ABITS-1:0]   idx_b;
    logic               cos_inc;
    logic               sin_inc;
    logic               frame_start;
    logic               start_clear;
    logic               clr_now;
    logic               silent_now;
    logic [ACCUM-1:0]   old_cos;
    logic [ACCUM-1:0]   old_sin;
    logic [ACCUM-1:0]   new_cos;
    logic [ACCUM-1:0]   new_sin;
    logic               ovf_cos;
    logic               ovf_sin;

    always_comb begin
        pair = '0;
        for (int k = 0; k < TRATE; k++) begin
            if (slot == TBITS'(k)) begin
                pair = PAIRS[k*2*ABITS +: 2*ABITS];
            end
        end
        idx_a   = pair[ABITS-1:0];
        idx_b   = pair[2*ABITS-1:ABITS];
        cos_inc = bus.re[idx_a] ~^ bus.re[idx_b];
        sin_inc = bus.re[idx_a] ~^ bus.im[idx_b];

        // A clearing frame is decided once, at slot 0, and then latched for the frame.
        frame_start = bus.en && (slot == '0);
        start_clear = frame_start && (pending_q || forced_clr);
        clr_now     = frame_start ? start_clear : in_clr;
        silent_now  = frame_start ? forced_clr  : in_silent;

        old_cos = a_clr ? '0 : a_old[ACCUM-1:0];
        old_sin = a_clr ? '0 : a_old[2*ACCUM-1:ACCUM];
        ovf_cos = a_vld && a_cinc && (old_cos == ONES);
        ovf_sin = a_vld && a_sinc && (old_sin == ONES);
        new_cos = ovf_cos ? ((SATURATE != 0) ? ONES : '0) : old_cos + ACCUM'(a_cinc);
        new_sin = ovf_sin ? ((SATURATE != 0) ? ONES : '0) : old_sin + ACCUM'(a_sinc);
    end

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= '0;
            forced_clr <= 1'b1;
            in_clr     <= 1'b0;
            in_silent  <= 1'b0;
            pending_q  <= 1'b0;
            swack_q    <= 1'b0;
            sticky_cos <= 1'b0;
            sticky_sin <= 1'b0;
            ovf_cos_q  <= 1'b0;
            ovf_sin_q  <= 1'b0;
            a_vld      <= 1'b0;
            a_slot     <= '0;
            a_cinc     <= 1'b0;
            a_sinc     <= 1'b0;
            a_clr      <= 1'b0;
            a_emit     <= 1'b0;
            a_old      <= '0;
            vld_q      <= 1'b0;
            vis_q      <= '0;
            vis_idx_q  <= '0;
        end else begin
            // sw on the very cycle a clear starts survives and triggers the next frame's clear
            pending_q <= bus.sw || (pending_q && !start_clear);
            swack_q   <= start_clear && !forced_clr;

            if (bus.en) begin
                slot      <= (slot == LAST) ? '0 : slot + TBITS'(1);
                in_clr    <= clr_now;
                in_silent <= silent_now;
                if (frame_start) begin
                    forced_clr <= 1'b0;
                end
                a_slot <= slot;
                a_cinc <= cos_inc;
                a_sinc <= sin_inc;
                a_clr  <= clr_now;
                a_emit <= clr_now && !silent_now;
                a_old  <= mem[slot];
            end
            a_vld <= bus.en;

            vld_q <= a_vld && a_emit;
            if (a_vld) begin
                vis_q     <= a_old;
                vis_idx_q <= a_slot;
            end

            // Stage A during the clear-start cycle still belongs to the old block,
            // so its overflow is folded into the reported flags.
            if (start_clear) begin
                if (!forced_clr) begin
                    ovf_cos_q <= sticky_cos || ovf_cos;
                    ovf_sin_q <= sticky_sin || ovf_sin;
                end
                sticky_cos <= 1'b0;
                sticky_sin <= 1'b0;
            end else begin
                sticky_cos <= sticky_cos || ovf_cos;
                sticky_sin <= sticky_sin || ovf_sin;
            end
        end
    end

    // Accumulator RAM is deliberately left unreset; a forced clearing frame initialises it.
    always_ff @(posedge clk_x) begin
        if (a_vld) begin
            mem[a_slot] <= {new_sin, new_cos};
        end
    end

    assign bus.vld          = vld_q;
    assign bus.vis          = vis_q;
    assign bus.vis_idx      = vis_idx_q;
    assign bus.swack        = swack_q;
    assign bus.pending      = pending_q;
    assign bus.overflow_cos = ovf_cos_q;
    assign bus.overflow_sin = ovf_sin_q;
endmodule

// File: tb/tb_correlator_tdm.sv
// tb/tb_correlator_tdm.sv - bench for correlator_tdm (24-bit, 3-bit saturating, 3-bit wrapping)
module tb_correlator_tdm;
    logic        clk_x = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sw;
    logic [23:0] re;
    logic [23:0] im;

    always #5 clk_x = ~clk_x;

    correlator_tdm_if #(.NANT(24), .ACCUM(24), .TBITS(4)) bm();
    correlator_tdm_if #(.NANT(24), .ACCUM(3),  .TBITS(4)) bs();
    correlator_tdm_if #(.NANT(24), .ACCUM(3),  .TBITS(4)) bw();

    assign bm.en = en;  assign bm.sw = sw;  assign bm.re = re;  assign bm.im = im;
    assign bs.en = en;  assign bs.sw = sw;  assign bs.re = re;  assign bs.im = im;
    assign bw.en = en;  assign bw.sw = sw;  assign bw.re = re;  assign bw.im = im;

    correlator_tdm #(.ACCUM(24), .SATURATE(1)) u_main (.clk_x(clk_x), .rst_n(rst_n), .bus(bm));
    correlator_tdm #(.ACCUM(3),  .SATURATE(1)) u_sat  (.clk_x(clk_x), .rst_n(rst_n), .bus(bs));
    correlator_tdm #(.ACCUM(3),  .SATURATE(0)) u_wrap (.clk_x(clk_x), .rst_n(rst_n), .bus(bw));

    int total = 0;
    int bad   = 0;

    int nm = 0, ns = 0, nw = 0, nsw = 0;
    logic [3:0]  m_idx [32];
    logic [23:0] m_cos [32];
    logic [23:0] m_sin [32];
    logic [2:0]  s_cos [32];
    logic [2:0]  s_sin [32];
    logic [2:0]  w_cos [32];
    logic [2:0]  w_sin [32];

    always @(negedge clk_x) begin
        if (bm.vld) begin
            if (nm < 32) begin
                m_idx[nm] = bm.vis_idx;
                m_cos[nm] = bm.vis[23:0];
                m_sin[nm] = bm.vis[47:24];
            end
            nm = nm + 1;
        end
        if (bs.vld) begin
            if (ns < 32) begin
                s_cos[ns] = bs.vis[2:0];
                s_sin[ns] = bs.vis[5:3];
            end
            ns = ns + 1;
        end
        if (bw.vld) begin
            if (nw < 32) begin
                w_cos[nw] = bw.vis[2:0];
                w_sin[nw] = bw.vis[5:3];
            end
            nw = nw + 1;
        end
        if (bm.swack) nsw = nsw + 1;
    end

    typedef struct {
        logic [23:0] re;
        logic [23:0] im;
        int          nfr;
        bit          gap;
        int          em;
        int          es;
        int          ew;
        bit          osc;
        bit          oss;
        bit          owc;
        bit          ows;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic s);
        en = e;
        sw = s;
        @(posedge clk_x);
        #1;
        en = 1'b0;
        sw = 1'b0;
    endtask

    task automatic clear_counts();
        nm = 0; ns = 0; nw = 0; nsw = 0;
    endtask

    task automatic run_frame(input bit gap, input int sw_at, input bit chk_swap);
        for (int k = 0; k < 12; k++) begin
            if (k == 0 && chk_swap) chk("pending_before_start", bm.pending, 1);
            cyc(1'b1, k == sw_at);
            if (k == 0 && chk_swap) begin
                chk("swack_at_start", bm.swack, 1);
                chk("pending_cleared", bm.pending, 0);
            end
            if (k == 1 && chk_swap) chk("swack_one_cycle", bm.swack, 0);
            if (sw_at >= 0 && (k == sw_at || k == 11)) chk($sformatf("pending_held_k%0d", k), bm.pending, 1);
            if (gap) cyc(1'b0, 1'b0);
        end
    endtask

    task automatic check_readout(input string tag, input logic [23:0] r, input logic [23:0] i,
                                 input int em, input int es, input int ew,
                                 input bit osc, input bit oss, input bit owc, input bit ows);
        logic ci, si;
        chk({tag, "_m_count"}, nm, 12);
        chk({tag, "_s_count"}, ns, 12);
        chk({tag, "_w_count"}, nw, 12);
        chk({tag, "_swack_count"}, nsw, 1);
        for (int k = 0; k < 12; k++) begin
            ci = ~(r[k] ^ r[k+12]);
            si = ~(r[k] ^ i[k+12]);
            chk($sformatf("%s_m_idx%0d", tag, k), m_idx[k], k);
            chk($sformatf("%s_m_cos%0d", tag, k), m_cos[k], ci ? em : 0);
            chk($sformatf("%s_m_sin%0d", tag, k), m_sin[k], si ? em : 0);
            chk($sformatf("%s_s_cos%0d", tag, k), s_cos[k], ci ? es : 0);
            chk($sformatf("%s_s_sin%0d", tag, k), s_sin[k], si ? es : 0);
            chk($sformatf("%s_w_cos%0d", tag, k), w_cos[k], ci ? ew : 0);
            chk($sformatf("%s_w_sin%0d", tag, k), w_sin[k], si ? ew : 0);
        end
        chk({tag, "_m_ovf_cos"}, bm.overflow_cos, 0);
        chk({tag, "_m_ovf_sin"}, bm.overflow_sin, 0);
        chk({tag, "_s_ovf_cos"}, bs.overflow_cos, osc);
        chk({tag, "_s_ovf_sin"}, bs.overflow_sin, oss);
        chk({tag, "_w_ovf_cos"}, bw.overflow_cos, owc);
        chk({tag, "_w_ovf_sin"}, bw.overflow_sin, ows);
    endtask

    task automatic run_vector(input vec_t v, input int vi);
        re = v.re;
        im = v.im;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        for (int f = 0; f < v.nfr; f++) begin
            run_frame(v.gap, (f == v.nfr - 1) ? 5 : -1, 1'b0);
        end
        if (vi == 0) chk("no_vld_before_swap", nm, 0);
        clear_counts();
        run_frame(v.gap, -1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        check_readout($sformatf("v%0d", vi), v.re, v.im, v.em, v.es, v.ew, v.osc, v.oss, v.owc, v.ows);
    endtask

    initial begin
        //             re          im          nfr gap em  es ew osc oss owc ows
        tbl[0] = '{24'hffffff, 24'hffffff, 2,  1'b0, 2,  2, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{24'h000fff, 24'h000000, 5,  1'b0, 5,  5, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{24'hffffff, 24'hffffff, 10, 1'b0, 10, 7, 2, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{24'hffffff, 24'hffffff, 2,  1'b1, 2,  2, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{24'h000000, 24'hffffff, 3,  1'b1, 3,  3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{24'h000001, 24'h000000, 9,  1'b0, 9,  7, 1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{24'h001000, 24'h800000, 8,  1'b0, 8,  7, 0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        sw    = 1'b0;
        re    = '0;
        im    = '0;
        repeat (3) @(posedge clk_x);
        #1;
        chk("rst_vld",     bm.vld, 0);
        chk("rst_swack",   bm.swack, 0);
        chk("rst_pending", bm.pending, 0);
        chk("rst_ovf_cos", bm.overflow_cos, 0);
        chk("rst_ovf_sin", bm.overflow_sin, 0);
        chk("rst_vis",     bm.vis, 0);
        chk("rst_vis_idx", bm.vis_idx, 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);

        for (int vi = 0; vi < 7; vi++) begin
            run_vector(tbl[vi], vi);
        end

        // Reset in the middle of a readout frame, with a fresh request already pending.
        re = 24'hffffff;
        im = 24'hffffff;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        run_frame(1'b0, -1, 1'b0);
        run_frame(1'b0, 5, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b1, k == 3);
        chk("mid_pending_rearmed", bm.pending, 1);
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",     bm.vld, 0);
        chk("mid_rst_swack",   bm.swack, 0);
        chk("mid_rst_pending", bm.pending, 0);
        chk("mid_rst_vis",     bm.vis, 0);
        chk("mid_rst_vis_idx", bm.vis_idx, 0);
        chk("mid_rst_ovf_cos", bs.overflow_cos, 0);
        @(posedge clk_x);
        #1;
        en    = 1'b0;
        rst_n = 1'b1;
        clear_counts();
        cyc(1'b0, 1'b0);
        run_frame(1'b0, -1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        chk("post_rst_silent_vld", nm, 0);
        chk("post_rst_no_swack", nsw, 0);
        chk("post_rst_pending", bm.pending, 0);
        run_frame(1'b0, 5, 1'b0);
        clear_counts();
        run_frame(1'b0, -1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        check_readout("post_rst", re, im, 2, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
